// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - start/done handshake and operand/product bus for mul_seq
interface mul_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, sgn, a, b, input busy, done, hi, lo);
  modport slave  (input start, sgn, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - radix-2 sequential shift-add multiplier, fixed WIDTH+1 cycle latency
module mul_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  mul_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand, mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_neg;
  logic               last_iter;

  // Magnitudes: -x of the most-negative value is itself, which is the correct unsigned magnitude.
  assign a_mag     = (bus.sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (bus.sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_neg   = ~acc + 1'b1;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_r;
    bus.hi   = hi_r;
    bus.lo   = lo_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          // Carry out of the upper-half add becomes the new MSB after the shift.
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          cnt    <= last_iter ? '0 : cnt + 1'b1;
        end
        FIX: begin
          {hi_r, lo_r} <= neg ? acc_neg : acc;
          done_r       <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq with random and corner operands
module tb_mul_seq;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [63:0] prod;
    int          e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [63:0] model_last = '0;

  mul_seq_if #(.WIDTH(W)) bus ();
  mul_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint px;
    if (s) begin
      px = longint'($signed(x)) * longint'($signed(y));
      return px;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every result pulse is matched against the scoreboard; outside pulses hi/lo must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          check("product", {bus.hi, bus.lo}, sb[0].prod);
          check("latency", 64'(cyc - sb[0].e0), 64'(LAT));
          check("busy_in_done", {63'b0, bus.busy}, 64'd0);
          model_last = sb[0].prod;
          void'(sb.pop_front());
        end
      end else begin
        check("hold_hi_lo", {bus.hi, bus.lo}, model_last);
      end
    end
  end

  // Caller is at a negedge; returns one posedge (+1) later.
  task automatic issue(input bit s, input logic [31:0] x, input logic [31:0] y, input bit accept);
    exp_t e;
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.a     = x;
    bus.b     = y;
    check("start_accept", {63'b0, ~bus.busy}, {63'b0, accept});
    @(posedge clk);
    #1;
    if (accept) begin
      e.prod = ref_mul(s, x, y);
      e.e0   = cyc;
      sb.push_back(e);
    end
    bus.start = 1'b0;
    bus.sgn   = 1'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (n >= 200) begin
      check("wait_idle_timeout", 64'd1, 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    if (n >= 100) check("wait_done_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    model_last = '0;
    rst = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);

    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    check("busy_after_start", {63'b0, bus.busy}, 64'd1);
    wait_idle();
    check("umax_result", model_last, 64'hFFFF_FFFE_0000_0001);
    issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
    check("neg1_sq", model_last, 64'h0000_0000_0000_0001);
    issue(1, 32'h8000_0000, 32'h8000_0000, 1); wait_idle();
    check("minval_sq", model_last, 64'h4000_0000_0000_0000);
    issue(1, 32'hFFFF_FFFD, 32'd5, 1); wait_idle();
    check("neg3_x5", model_last, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(0, 32'h8000_0000, 32'd2, 1); wait_idle();
    check("u_min_x2", model_last, 64'h0000_0001_0000_0000);
    issue(1, 32'h8000_0000, 32'd2, 1); wait_idle();
    check("s_min_x2", model_last, 64'hFFFF_FFFF_0000_0000);

    // Start while busy is ignored.
    issue(0, 32'd7, 32'd6, 1);
    repeat (9) @(negedge clk);
    issue(0, 32'd9, 32'd9, 0);
    wait_idle();
    check("busy_reject", model_last, 64'd42);
    repeat (40) @(negedge clk);

    // Reset mid-operation: no done, state cleared, fresh op still correct.
    issue(0, 32'd5, 32'd5, 1);
    repeat (11) @(negedge clk);
    pulse_reset();
    @(negedge clk);
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (40) @(negedge clk);
    issue(0, 32'd5, 32'd5, 1); wait_idle();
    check("after_abort", model_last, 64'd25);

    // Back-to-back issue in the done cycle.
    issue(0, 32'd3, 32'd4, 1);
    wait_done();
    issue(0, 32'd0, 32'h1234_5678, 1);
    wait_idle();
    check("b2b_zero", model_last, 64'd0);

    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 2) begin
        issue(1'($urandom), pick(), pick(), 1);
        wait_done();
        issue(1'($urandom), pick(), pick(), 1);
      end else begin
        issue(1'($urandom), pick(), pick(), 1);
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
